// File: rtl/usb3_crc_pkg.sv
// Shared types and helpers for the USB3 streaming CRC engine.
// Reflected (LSB-first) CRCs narrower than 32 bits live in the low bits with zeros above.
package usb3_crc_pkg;

  localparam logic [31:0] CRC32_POLY_R  = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] CRC16_POLY_R  = 16'hD008;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // One byte through a reflected shift-right LFSR, bit 0 first.
  function automatic logic [31:0] crc_byte(input logic [31:0] lfsr,
                                           input logic [7:0]  data,
                                           input logic [31:0] poly);
    logic [31:0] r;
    r = lfsr;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ data[i]) ? ((r >> 1) ^ poly) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/usb3_crc_fold.sv
// Combinational fold of the first nbytes bytes of a beat into the LFSR, byte 0 first.
module usb3_crc_fold
  import usb3_crc_pkg::*;
#(
  parameter int          CRC_W  = 32,
  parameter int          DATA_W = 32,
  parameter logic [31:0] POLY_M = CRC32_POLY_R
) (
  input  logic [CRC_W-1:0]               lfsr_in,
  input  logic [DATA_W-1:0]              data,
  input  logic [$clog2(DATA_W/8+1)-1:0]  nbytes,
  output logic [CRC_W-1:0]               lfsr_out
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = $clog2(NB + 1);

  logic [31:0] seed;
  logic [31:0] stage [0:NB];

  always_comb begin
    seed = '0;
    seed[CRC_W-1:0] = lfsr_in;
  end

  assign stage[0] = seed;

  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign stage[i+1] = (CNT_W'(i) < nbytes) ? crc_byte(stage[i], data[8*i +: 8], POLY_M)
                                             : stage[i];
  end

  assign lfsr_out = stage[NB][CRC_W-1:0];

endmodule

// File: rtl/usb3_crc_stream.sv
// Streaming CRC engine: GEN emits LFSR^XOROUT, CHK compares the LFSR with RESIDUE.
// Define USB3_CRC_ERRCNT_EN to add the saturating err_cnt output for failed CHK results.
module usb3_crc_stream
  import usb3_crc_pkg::*;
#(
  parameter int          CRC_W   = 32,
  parameter int          DATA_W  = 32,
  parameter logic [31:0] POLY_R  = CRC32_POLY_R,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE = CRC32_RESIDUE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode_chk,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_be,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CRC_W-1:0]    crc_out,
  output logic                crc_ok,
  output logic                busy
`ifdef USB3_CRC_ERRCNT_EN
  ,
  output logic [15:0]         err_cnt
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = $clog2(NB + 1);
  localparam logic [31:0] MASK = (CRC_W == 32) ? 32'hFFFFFFFF : ((32'h1 << CRC_W) - 32'h1);
  localparam logic [31:0] POLY_M = POLY_R & MASK;
  localparam logic [CRC_W-1:0] INIT_W = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_W  = XOROUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RES_W  = RESIDUE[CRC_W-1:0];

  state_t             state, state_nxt;
  logic [CRC_W-1:0]   lfsr, fold_out;
  logic               mode_q, mode_eff, accept, be_run;
  logic [CNT_W-1:0]   nbytes;

  assign accept   = in_valid && (state != DONE);
  assign mode_eff = (state == IDLE) ? mode_chk : mode_q;

  // Last beat folds only the contiguous run of enabled bytes starting at byte 0.
  always_comb begin
    nbytes = CNT_W'(NB);
    be_run = 1'b1;
    if (in_last) begin
      nbytes = '0;
      for (int i = 0; i < NB; i++) begin
        if (be_run && in_be[i]) nbytes = nbytes + 1'b1;
        else                    be_run = 1'b0;
      end
    end
  end

  usb3_crc_fold #(
    .CRC_W  (CRC_W),
    .DATA_W (DATA_W),
    .POLY_M (POLY_M)
  ) u_fold (
    .lfsr_in  (lfsr),
    .data     (in_data),
    .nbytes   (nbytes),
    .lfsr_out (fold_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (in_valid) state_nxt = in_last ? DONE : ACCUM;
      end
      ACCUM: begin
        if (in_valid && in_last) state_nxt = DONE;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The LFSR restarts from INIT as the result is captured, ready for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= INIT_W;
      mode_q  <= 1'b0;
      crc_out <= '0;
      crc_ok  <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) mode_q <= mode_chk;
      if (in_last) begin
        lfsr    <= INIT_W;
        crc_out <= fold_out ^ XOR_W;
        crc_ok  <= mode_eff ? (fold_out == RES_W) : 1'b1;
      end else begin
        lfsr <= fold_out;
      end
    end
  end

`ifdef USB3_CRC_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && mode_q && !crc_ok && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb3_crc_stream.sv
// Randomised bench for usb3_crc_stream: CRC-32/32-bit and CRC-16/16-bit instances
// checked against a bit-serial reference model of the reflected CRC.
module tb_usb3_crc_stream;
  import usb3_crc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        mode_chk, in_valid, in_last, out_ready;
  logic [63:0] in_data;
  logic [7:0]  in_be;

  logic        rdy32, ov32, ok32, busy32;
  logic [31:0] crc32;
  logic        rdy16, ov16, ok16, busy16;
  logic [15:0] crc16;

  always #5 clk = ~clk;

  usb3_crc_stream u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_chk  (mode_chk),
    .in_valid  (in_valid && !sel),
    .in_ready  (rdy32),
    .in_data   (in_data[31:0]),
    .in_be     (in_be[3:0]),
    .in_last   (in_last),
    .out_valid (ov32),
    .out_ready (out_ready || sel),
    .crc_out   (crc32),
    .crc_ok    (ok32),
    .busy      (busy32)
`ifdef USB3_CRC_ERRCNT_EN
    ,
    .err_cnt   (err32)
`endif
  );

  usb3_crc_stream #(
    .CRC_W   (16),
    .DATA_W  (16),
    .POLY_R  ({16'h0000, CRC16_POLY_R}),
    .INIT    (32'h0000FFFF),
    .XOROUT  (32'h00000000),
    .RESIDUE (32'h00000000)
  ) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_chk  (mode_chk),
    .in_valid  (in_valid && sel),
    .in_ready  (rdy16),
    .in_data   (in_data[15:0]),
    .in_be     (in_be[1:0]),
    .in_last   (in_last),
    .out_valid (ov16),
    .out_ready (out_ready || !sel),
    .crc_out   (crc16),
    .crc_ok    (ok16),
    .busy      (busy16)
`ifdef USB3_CRC_ERRCNT_EN
    ,
    .err_cnt   (err16)
`endif
  );

`ifdef USB3_CRC_ERRCNT_EN
  logic [15:0] err32, err16;
  logic [15:0] expErr [2];
`endif

  wire        mReady = sel ? rdy16 : rdy32;
  wire        mValid = sel ? ov16  : ov32;
  wire        mOk    = sel ? ok16  : ok32;
  wire        mBusy  = sel ? busy16 : busy32;
  wire [31:0] mCrc   = sel ? {16'h0000, crc16} : crc32;

  int tests = 0;
  int fails = 0;
  byte unsigned frameBytes[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raw register after shifting every frame byte in, LSB first, one bit at a time.
  function automatic logic [31:0] modelLfsr();
    logic [31:0] poly, r;
    poly = sel ? 32'h0000D008 : 32'hEDB88320;
    r    = sel ? 32'h0000FFFF : 32'hFFFFFFFF;
    foreach (frameBytes[k]) begin
      for (int b = 0; b < 8; b++) begin
        if (((r ^ (32'(frameBytes[k]) >> b)) & 32'd1) != 0) r = (r >> 1) ^ poly;
        else                                                 r = r >> 1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] xorOut();
    return sel ? 32'h0 : 32'hFFFFFFFF;
  endfunction

  function automatic logic [31:0] residue();
    return sel ? 32'h0 : 32'hDEBB20E3;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit chk, input bit gaps);
    int nb, n, nbeats, idx, waitCnt, cnt;
    bit isLast;
    nb = sel ? 2 : 4;
    n = frameBytes.size();
    nbeats = (n == 0) ? 1 : (n + nb - 1) / nb;
    idx = 0;
    for (int b = 0; b < nbeats; b++) begin
      isLast = (b == nbeats - 1);
      cnt = isLast ? n - idx : nb;
      while (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        mode_chk = 1'($urandom);
        tick();
      end
      in_data = {$urandom, $urandom};
      for (int k = 0; k < cnt; k++) in_data[8*k +: 8] = frameBytes[idx + k];
      in_be = 8'($urandom);
      if (isLast) begin
        for (int k = 0; k < cnt; k++) in_be[k] = 1'b1;
        if (cnt < nb) in_be[cnt] = 1'b0;
      end
      mode_chk = (b == 0) ? chk : 1'($urandom);
      in_last  = isLast;
      in_valid = 1'b1;
      waitCnt = 0;
      while (!mReady && waitCnt < 50) begin
        tick();
        waitCnt++;
      end
      if (!mReady) checkOutput("acceptTimeout", 64'(mReady), 64'd1);
      tick();
      idx += cnt;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("latency", 64'(mValid), 64'd1);
  endtask

  task automatic collectResult(input bit chk, input bit gaps, input logic [31:0] expCrc, input bit expOk);
    int hold;
    hold = 0;
    checkOutput("crcOut", 64'(mCrc), 64'(expCrc));
    checkOutput("crcOk", 64'(mOk), 64'(expOk));
    out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!out_ready) begin
      tick();
      hold++;
      checkOutput("crcHold", 64'(mCrc), 64'(expCrc));
      checkOutput("validHold", 64'(mValid), 64'd1);
      out_ready = (hold > 6) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    tick();
`ifdef USB3_CRC_ERRCNT_EN
    if (chk && !expOk && expErr[sel] != 16'hFFFF) expErr[sel]++;
    checkOutput("errCnt", 64'(sel ? err16 : err32), 64'(expErr[sel]));
`endif
    checkOutput("validDrop", 64'(mValid), 64'd0);
    out_ready = 1'b0;
  endtask

  task automatic runFrame(input bit chk, input bit gaps);
    logic [31:0] lf, mask;
    mask = sel ? 32'h0000FFFF : 32'hFFFFFFFF;
    lf = modelLfsr();
    applyStimulus(chk, gaps);
    collectResult(chk, gaps, (lf ^ xorOut()) & mask, chk ? (lf == residue()) : 1'b1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_inReady"}, 64'(mReady), 64'd1);
    checkOutput({tag, "_outValid"}, 64'(mValid), 64'd0);
    checkOutput({tag, "_crcOut"}, 64'(mCrc), 64'd0);
    checkOutput({tag, "_crcOk"}, 64'(mOk), 64'd0);
    checkOutput({tag, "_busy"}, 64'(mBusy), 64'd0);
  endtask

  task automatic loadCheckString();
    frameBytes = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] lf;
    int len;
    bit chk;
    rst_n = 1'b0; sel = 1'b0; mode_chk = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_data = '0; in_be = '0;
`ifdef USB3_CRC_ERRCNT_EN
    expErr[0] = '0;
    expErr[1] = '0;
`endif
    tick();
    tick();
    checkResetState("reset32");
    sel = 1'b1;
    checkResetState("reset16");
    sel = 1'b0;
    rst_n = 1'b1;
    tick();

    loadCheckString();
    applyStimulus(1'b0, 1'b0);
    collectResult(1'b0, 1'b0, 32'hCBF43926, 1'b1);

    frameBytes.push_back(8'h26); frameBytes.push_back(8'h39);
    frameBytes.push_back(8'hF4); frameBytes.push_back(8'hCB);
    applyStimulus(1'b1, 1'b0);
    collectResult(1'b1, 1'b0, 32'h2144DF1C, 1'b1);
    frameBytes[0] = frameBytes[0] ^ 8'h01;
    runFrame(1'b1, 1'b0);

    loadCheckString();
    applyStimulus(1'b0, 1'b0);
    out_ready = 1'b0;
    in_data = 64'h34333231; in_be = 8'h0F; in_last = 1'b0; mode_chk = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checkOutput("bpInReady", 64'(mReady), 64'd0);
      checkOutput("bpValid", 64'(mValid), 64'd1);
      checkOutput("bpCrcHeld", 64'(mCrc), 64'hCBF43926);
      tick();
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bpValidDrop", 64'(mValid), 64'd0);
    checkOutput("bpInReadyBack", 64'(mReady), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 1'b0);
    collectResult(1'b0, 1'b0, 32'hCBF43926, 1'b1);

    frameBytes = {};
    applyStimulus(1'b0, 1'b0);
    collectResult(1'b0, 1'b0, 32'h00000000, 1'b1);

    in_data = 64'h34333231; in_be = 8'h0F; in_last = 1'b0; mode_chk = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("midBusy", 64'(mBusy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkResetState("midReset");
`ifdef USB3_CRC_ERRCNT_EN
    expErr[0] = '0;
    expErr[1] = '0;
    checkOutput("midResetErr", 64'(err32), 64'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    loadCheckString();
    applyStimulus(1'b0, 1'b0);
    collectResult(1'b0, 1'b0, 32'hCBF43926, 1'b1);

    for (int r = 0; r < 100; r++) begin
      sel = (r >= 60);
      len = $urandom_range(1, 64);
      chk = 1'($urandom);
      frameBytes = {};
      for (int k = 0; k < len; k++) frameBytes.push_back(8'($urandom));
      if (chk && $urandom_range(0, 1) == 1) begin
        lf = modelLfsr() ^ xorOut();
        for (int k = 0; k < (sel ? 2 : 4); k++) frameBytes.push_back(lf[8*k +: 8]);
      end
      runFrame(chk, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
